// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes stage: one 128-bit state is substituted LANES
// bytes per cycle, byte 0 (MSB) first, with valid/ready handshakes on both
// sides and a DONE state that can hand over and reload on the same edge.

// Single AES forward S-box lookup (FIPS-197 table, row = high nibble).
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits at the top of the packed table.
  logic [10:0] w_idx;
  assign w_idx  = 11'd2047 - {i_byte, 3'b000};
  assign o_byte = SBOX_TBL[w_idx -: 8];

endmodule

module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int CHUNKS = 16 / LANES;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [127:0]     r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_base;
  logic [7:0]       w_bytes    [16];
  logic [7:0]       w_lane_in  [LANES];
  logic [7:0]       w_lane_out [LANES];
  logic [127:0]     w_st_sub;

  // First byte index of the chunk being substituted this cycle.
  assign w_base = 4'(r_cnt * LANES);
  assign w_last = (r_cnt == CNT_W'(CHUNKS - 1));

  for (genvar b = 0; b < 16; b++) begin : g_bytes
    assign w_bytes[b] = r_st[127 - 8*b -: 8];
  end

  // The only substitution hardware: LANES S-boxes fed from the current chunk.
  for (genvar l = 0; l < LANES; l++) begin : g_lanes
    assign w_lane_in[l] = w_bytes[w_base + 4'(l)];
    aes_sbox u_sbox (
      .i_byte (w_lane_in[l]),
      .o_byte (w_lane_out[l])
    );
  end

  // Byte b belongs to chunk b/LANES and is served by lane b%LANES.
  for (genvar b = 0; b < 16; b++) begin : g_merge
    localparam int CH = b / LANES;
    localparam int LN = b % LANES;
    assign w_st_sub[127 - 8*b -: 8] =
      (r_cnt == CNT_W'(CH)) ? w_lane_out[LN] : w_bytes[b];
  end

  assign w_accept = in_valid & in_ready;
  assign out_data = r_st;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; DONE forwards out_ready to in_ready so
  // a finished result and a new state can swap on one edge.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Working state and chunk counter: load on accept, substitute one chunk per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_st  <= in_data;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_st  <= w_st_sub;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: LANES=4 main instance plus LANES=1,2,4,8,16
// instances sharing one stimulus for the full-table parameter sweep.
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  logic         sw_in_valid = 1'b0;
  logic [127:0] sw_in_data = '0;
  logic         sw_out_ready = 1'b1;
  logic         sw_ir [5];
  logic         sw_ov [5];
  logic         sw_bz [5];
  logic [127:0] sw_od [5];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_sb [256];

  always #5 clk = ~clk;

  sub_bytes_iter #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  for (genvar k = 0; k < 5; k++) begin : g_sw
    sub_bytes_iter #(.LANES(1 << k)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_ir[k]),
      .in_data(sw_in_data), .out_valid(sw_ov[k]), .out_ready(sw_out_ready),
      .out_data(sw_od[k]), .busy(sw_bz[k])
    );
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_def(input logic [7:0] x);
    logic [7:0] inv;
    inv = '0;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = ref_sb[s[127 - 8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on the main DUT; lat counts edges with the accepting edge as 1.
  task automatic run_one(input logic [127:0] din, input int stall,
                         output logic [127:0] dout, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    in_data = din; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      in_data = rnd128();
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    repeat (stall) begin @(posedge clk); #1; end
    dout = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [4];
    logic [127:0] d, a, b, hold, din;
    int lat, e, pulses;
    logic seen [5];
    int sl [5];
    logic [127:0] got [5];

    for (int i = 0; i < 256; i++) ref_sb[i] = sbox_def(8'(i));

    vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vt[1] = '{128'h0, {16{8'h63}}};
    vt[2] = '{{16{8'hff}}, {16{8'h16}}};
    vt[3] = '{128'h53000000000000000000000000000000, 128'hed636363636363636363636363636363};

    // Reset state, forced without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_data", out_data, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Known-answer vectors.
    for (int i = 0; i < 4; i++) begin
      run_one(vt[i].din, 0, d, lat);
      chk($sformatf("vec%0d data", i), d, vt[i].dout);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'd5);
    end

    // Random states with random output stalls and RUN-time in_data noise.
    for (int i = 0; i < 16; i++) begin
      din = rnd128();
      run_one(din, int'($urandom_range(0, 3)), d, lat);
      chk($sformatf("rand%0d data", i), d, ref_sub(din));
      chk($sformatf("rand%0d latency", i), 128'(lat), 128'd5);
    end

    // Backpressure: DONE held for 10 cycles while in_valid toggles.
    a = rnd128();
    in_data = a; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 0;
    while (!out_valid && e < 40) begin @(posedge clk); #1; e++; end
    hold = out_data;
    chk("bp result", hold, ref_sub(a));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = rnd128();
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp%0d out_data", i), out_data, hold);
      chk($sformatf("bp%0d in_ready", i), 128'(in_ready), 128'd0);
      chk($sformatf("bp%0d busy", i), 128'(busy), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 128'(out_valid), 128'd0);
    chk("bp release busy", 128'(busy), 128'd0);
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) pulses++; end
    chk("bp extra results", 128'(pulses), 128'd0);

    // Back-to-back: second state accepted on the DONE-exit edge.
    a = rnd128(); b = rnd128();
    in_data = a; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = b;
    e = 1;
    while (!out_valid && e < 40) begin @(posedge clk); #1; e++; end
    chk("b2b first data", out_data, ref_sub(a));
    chk("b2b in_ready in DONE", 128'(in_ready), 128'd1);
    chk("b2b period", 128'(e), 128'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b reload busy", 128'(busy), 128'd1);
    chk("b2b reload out_valid", 128'(out_valid), 128'd0);
    e = 1;
    while (!out_valid && e < 40) begin @(posedge clk); #1; e++; end
    chk("b2b second data", out_data, ref_sub(b));
    chk("b2b second latency", 128'(e), 128'd5);
    @(posedge clk); #1;

    // Reset after two chunks of RUN, then a clean state right after release.
    in_data = rnd128(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun busy before reset", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", 128'(busy), 128'd0);
    chk("midrun reset out_valid", 128'(out_valid), 128'd0);
    chk("midrun reset in_ready", 128'(in_ready), 128'd1);
    chk("midrun reset out_data", out_data, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_data = vt[3].din; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post-reset first-edge accept", 128'(busy), 128'd1);
    e = 1;
    while (!out_valid && e < 40) begin @(posedge clk); #1; e++; end
    chk("post-reset latency", 128'(e), 128'd5);
    chk("post-reset data", out_data, vt[3].dout);
    @(posedge clk); #1;

    // Parameter sweep: every byte value through every LANES setting.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) din[127 - 8*i -: 8] = 8'(j*16 + i);
      sw_in_data = din; sw_in_valid = 1'b1;
      @(posedge clk); #1;
      sw_in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin seen[k] = 1'b0; sl[k] = 0; got[k] = '0; end
      for (int t = 1; t <= 24; t++) begin
        for (int k = 0; k < 5; k++)
          if (!seen[k] && sw_ov[k]) begin seen[k] = 1'b1; sl[k] = t; got[k] = sw_od[k]; end
        @(posedge clk); #1;
      end
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("sweep L%0d st%0d data", 1 << k, j), got[k], ref_sub(din));
        chk($sformatf("sweep L%0d st%0d latency", 1 << k, j), 128'(sl[k]), 128'(16 / (1 << k) + 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_iter.md
SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_data is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a state this cycle.
REQ-006 SHALL have port in_data  input  128  AES state; byte i = in_data[127-8i -: 8], byte 0 at the MSB.
REQ-007 SHALL have port out_valid  output  1  out_data holds a completed SubBytes result.
REQ-008 SHALL have port out_ready  input  1  downstream (ShiftRows stage) accepts out_data.
REQ-009 SHALL have port out_data  output  128  substituted state, same byte order as in_data.
REQ-010 SHALL have port busy  output  1  FSM is in RUN.

Function
REQ-011 SHALL contain exactly LANES instances of the standard AES forward S-box (FIPS-197) and no other substitution logic.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE in a 128-bit working register st and a chunk counter cnt of width clog2(16/LANES), minimum 1 bit.
REQ-013 in_ready SHALL be 1 in IDLE, equal to out_ready in DONE, and 0 in RUN.
REQ-014 An input handshake (in_valid & in_ready) SHALL load st <= in_data, set cnt <= 0 and move to RUN.
REQ-015 In RUN, each cycle SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 of st with their S-box values, leaving all other bytes unchanged.
REQ-016 In RUN, each cycle SHALL increment cnt; when cnt == 16/LANES-1 the FSM SHALL move to DONE on that edge.
REQ-017 Chunks SHALL be processed in ascending byte order, starting with byte 0.
REQ-018 out_valid SHALL be 1 exactly when the FSM is in DONE, and out_data SHALL equal st (registered, no combinational path from in_data).
REQ-019 Latency: out_valid SHALL rise 16/LANES+1 clock edges after the accepting edge (LANES=4: 5 edges).
REQ-020 In DONE with out_ready=0, out_valid and out_data SHALL be held stable, and in_valid SHALL be ignored.
REQ-021 In DONE with out_ready=1 and in_valid=0, the FSM SHALL move to IDLE.
REQ-022 In DONE with out_ready=1 and in_valid=1 (simultaneous handshakes), the result SHALL be delivered, the new state loaded, and the FSM moved directly to RUN with no idle bubble.
REQ-023 in_valid in RUN SHALL have no effect, and in_data changes during RUN SHALL not affect the result.
REQ-024 With LANES=16, RUN SHALL last exactly one cycle.
REQ-025 Throughput SHALL be one state per 16/LANES+1 cycles under continuous valid/ready.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, st=0, cnt=0, out_valid=0, busy=0 and in_ready=1.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the in-flight state; no out_valid pulse SHALL follow.
REQ-028 After rst_n deasserts, the first clk edge SHALL be able to accept input.

Verification
REQ-029 Single state (LANES=4): in_data = 00112233445566778899aabbccddeeff, out_ready=1 -> out_data = 638293c31bfc33f5c4eeacea4bc12816, out_valid rising 5 edges after acceptance.
REQ-030 All-zero input -> out_data = 6363...63 (16 bytes); all-ones input (ff..ff) -> 1616...16.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> out_data is stable, in_ready=0, no second state is accepted, and release delivers exactly one result.
REQ-032 Back-to-back: in_valid held high with two states and out_ready=1 -> second acceptance occurs on the DONE-exit edge, with no idle bubble and both results correct and in order.
REQ-033 Reset mid-RUN after 2 chunks -> outputs at reset values immediately; the next state (5300...00) yields ed63...63 with no stale bytes.
REQ-034 Parameter sweep with LANES=1, 2, 8 and 16 -> all 256 byte values verified against the FIPS-197 table, with latency equal to 16/LANES+1.
